// File: rtl/fighter_controller_if.sv
// Player control bus: frame timing, buttons, hit detection and opponent
// position in; sprite position, animation state and attack flag out.
interface fighter_controller_if;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_attack;
    logic       got_hit;
    logic [9:0] opponent_x;
    logic [9:0] player_x;
    logic [3:0] player_state;
    logic       attack_active;

    // Game-level side: drives inputs, consumes the player outputs
    modport master (
        output frame_tick,
        output btn_left,
        output btn_right,
        output btn_attack,
        output got_hit,
        output opponent_x,
        input  player_x,
        input  player_state,
        input  attack_active
    );

    // Fighter controller side
    modport slave (
        input  frame_tick,
        input  btn_left,
        input  btn_right,
        input  btn_attack,
        input  got_hit,
        input  opponent_x,
        output player_x,
        output player_state,
        output attack_active
    );
endinterface

// File: rtl/fighter_controller.sv
// Per-player game-state engine. Once per video frame it samples buttons and
// any pending hit, advances the walk/attack/hitstun state machine and moves
// the sprite, clamping to the screen edges and to the opponent.
module fighter_controller #(
    parameter int START_X         = 100,
    parameter int FACING_RIGHT    = 1,
    parameter int SPEED_FWD       = 3,
    parameter int SPEED_BACK      = 2,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 640,
    parameter int PLAYER_W        = 64,
    parameter int STARTUP_FRAMES  = 5,
    parameter int ACTIVE_FRAMES   = 2,
    parameter int RECOVERY_FRAMES = 16,
    parameter int HITSTUN_FRAMES  = 20
) (
    input logic                 clk,
    input logic                 reset,
    fighter_controller_if.slave bus
);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_WALK_FWD     = 4'd1,
        ST_WALK_BACK    = 4'd2,
        ST_ATK_STARTUP  = 4'd3,
        ST_ATK_ACTIVE   = 4'd4,
        ST_ATK_RECOVERY = 4'd5,
        ST_HITSTUN      = 4'd6
    } state_t;

    // Phase counter only has to hold the longest phase length minus one.
    localparam int MAX_AB     = (STARTUP_FRAMES > ACTIVE_FRAMES) ? STARTUP_FRAMES : ACTIVE_FRAMES;
    localparam int MAX_CD     = (RECOVERY_FRAMES > HITSTUN_FRAMES) ? RECOVERY_FRAMES : HITSTUN_FRAMES;
    localparam int MAX_FRAMES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CNT_W-1:0] STARTUP_LOAD  = CNT_W'(STARTUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LOAD   = CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LOAD = CNT_W'(RECOVERY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HITSTUN_LOAD  = CNT_W'(HITSTUN_FRAMES - 1);

    // Position arithmetic is done on 11 bits so sums and differences never wrap.
    localparam logic [10:0] X_LO    = 11'(X_MIN);
    localparam logic [10:0] X_HI    = 11'(X_MAX - PLAYER_W);
    localparam logic [10:0] PW      = 11'(PLAYER_W);
    localparam logic [10:0] SPD_FWD = 11'(SPEED_FWD);
    localparam logic [10:0] SPD_BCK = 11'(SPEED_BACK);
    localparam logic [9:0]  X_LO_10 = 10'(X_MIN);
    localparam logic [9:0]  X_HI_10 = 10'(X_MAX - PLAYER_W);
    localparam logic [9:0]  X_START = 10'(START_X);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [9:0]       x_reg, x_next;
    logic             prev_attack_reg, prev_attack_next;
    logic             hit_latch_reg, hit_latch_next;

    logic             hit_pending;
    logic             attack_press;
    logic             fwd_btn;
    logic             back_btn;
    logic [9:0]       fwd_x;
    logic [9:0]       back_x;

    // Move toward +x, capped at the right screen bound.
    function automatic logic [9:0] step_up(input logic [9:0] x, input logic [10:0] spd);
        logic [10:0] sum;
        sum = {1'b0, x} + spd;
        return (sum > X_HI) ? X_HI_10 : sum[9:0];
    endfunction

    // Move toward -x, floored at the left screen bound.
    function automatic logic [9:0] step_down(input logic [9:0] x, input logic [10:0] spd);
        logic [10:0] floor_x;
        logic [10:0] diff;
        floor_x = X_LO + spd;
        diff    = {1'b0, x} - spd;
        return ({1'b0, x} < floor_x) ? X_LO_10 : diff[9:0];
    endfunction

    // Keep a +x move at or below lim; if already past lim, stay put rather
    // than being pushed backward.
    function automatic logic [9:0] clamp_below(input logic [9:0] cand, input logic [9:0] x,
                                               input logic [10:0] lim);
        if ({1'b0, cand} > lim)
            return ({1'b0, x} > lim) ? x : lim[9:0];
        return cand;
    endfunction

    // Keep a -x move at or above lim; if already past lim, stay put.
    function automatic logic [9:0] clamp_above(input logic [9:0] cand, input logic [9:0] x,
                                               input logic [10:0] lim);
        if ({1'b0, cand} < lim)
            return ({1'b0, x} < lim) ? x : lim[9:0];
        return cand;
    endfunction

    // A hit arriving in the tick cycle itself still counts for that tick.
    assign hit_pending  = hit_latch_reg | bus.got_hit;
    assign attack_press = bus.btn_attack & ~prev_attack_reg;

    generate
        if (FACING_RIGHT != 0) begin : g_face_right
            logic [10:0] opp_lim;

            assign fwd_btn  = bus.btn_right & ~bus.btn_left;
            assign back_btn = bus.btn_left & ~bus.btn_right;

            // Forward is +x and may not close within one sprite width of the opponent.
            always_comb begin
                opp_lim = X_LO;
                if ({1'b0, bus.opponent_x} >= X_LO + PW)
                    opp_lim = {1'b0, bus.opponent_x} - PW;
                fwd_x  = clamp_below(step_up(x_reg, SPD_FWD), x_reg, opp_lim);
                back_x = step_down(x_reg, SPD_BCK);
            end
        end else begin : g_face_left
            logic [10:0] opp_lim;

            assign fwd_btn  = bus.btn_left & ~bus.btn_right;
            assign back_btn = bus.btn_right & ~bus.btn_left;

            // Forward is -x and must stay at least one sprite width right of the opponent.
            always_comb begin
                opp_lim = {1'b0, bus.opponent_x} + PW;
                fwd_x   = clamp_above(step_down(x_reg, SPD_FWD), x_reg, opp_lim);
                back_x  = step_up(x_reg, SPD_BCK);
            end
        end
    endgenerate

    // Next-state logic: hit latch runs every cycle, everything else only on frame_tick.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        x_next           = x_reg;
        prev_attack_next = prev_attack_reg;
        hit_latch_next   = hit_latch_reg | bus.got_hit;

        if (bus.frame_tick) begin
            hit_latch_next   = 1'b0;
            prev_attack_next = bus.btn_attack;

            if (hit_pending && (state_reg != ST_HITSTUN)) begin
                state_next = ST_HITSTUN;
                cnt_next   = HITSTUN_LOAD;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_WALK_FWD, ST_WALK_BACK: begin
                        if (attack_press) begin
                            state_next = ST_ATK_STARTUP;
                            cnt_next   = STARTUP_LOAD;
                        end else if (fwd_btn) begin
                            state_next = ST_WALK_FWD;
                            x_next     = fwd_x;
                        end else if (back_btn) begin
                            state_next = ST_WALK_BACK;
                            x_next     = back_x;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end

                    ST_ATK_STARTUP, ST_ATK_ACTIVE, ST_ATK_RECOVERY, ST_HITSTUN: begin
                        if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - CNT_W'(1);
                        end else begin
                            case (state_reg)
                                ST_ATK_STARTUP: begin
                                    state_next = ST_ATK_ACTIVE;
                                    cnt_next   = ACTIVE_LOAD;
                                end
                                ST_ATK_ACTIVE: begin
                                    state_next = ST_ATK_RECOVERY;
                                    cnt_next   = RECOVERY_LOAD;
                                end
                                default: state_next = ST_IDLE;
                            endcase
                        end
                    end

                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    // State, position, counter and latch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            x_reg           <= X_START;
            prev_attack_reg <= 1'b0;
            hit_latch_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            x_reg           <= x_next;
            prev_attack_reg <= prev_attack_next;
            hit_latch_reg   <= hit_latch_next;
        end
    end

    assign bus.player_x      = x_reg;
    assign bus.player_state  = state_reg;
    assign bus.attack_active = (state_reg == ST_ATK_ACTIVE);

endmodule

// File: tb/tb_fighter_controller.sv
// Bench for fighter_controller (P1 orientation). Each tick pushes the model's
// expected outputs to a queue; the scenario tasks pop and compare them.
module tb_fighter_controller;

    localparam int START_X         = 100;
    localparam int SPEED_FWD       = 3;
    localparam int SPEED_BACK      = 2;
    localparam int X_MIN           = 0;
    localparam int X_MAX           = 640;
    localparam int PLAYER_W        = 64;
    localparam int STARTUP_FRAMES  = 5;
    localparam int ACTIVE_FRAMES   = 2;
    localparam int RECOVERY_FRAMES = 16;
    localparam int HITSTUN_FRAMES  = 20;

    localparam int S_IDLE = 0, S_FWD = 1, S_BACK = 2, S_START = 3, S_ACT = 4, S_REC = 5, S_HIT = 6;

    typedef struct packed {
        logic [9:0] x;
        logic [3:0] st;
        logic       atk;
    } exp_t;

    typedef struct {
        bit l;
        bit r;
        bit a;
        int opp;
        int n;
        int exp_x;
        int exp_st;
    } phase_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fighter_controller_if bus();

    fighter_controller #(
        .START_X(START_X), .FACING_RIGHT(1), .SPEED_FWD(SPEED_FWD), .SPEED_BACK(SPEED_BACK),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .PLAYER_W(PLAYER_W),
        .STARTUP_FRAMES(STARTUP_FRAMES), .ACTIVE_FRAMES(ACTIVE_FRAMES),
        .RECOVERY_FRAMES(RECOVERY_FRAMES), .HITSTUN_FRAMES(HITSTUN_FRAMES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   m_x, m_state, m_cnt;
    bit   m_prev, m_hit;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    function automatic string fmt(input exp_t v);
        return $sformatf("x=%0d st=%0d atk=%0d", v.x, v.st, v.atk);
    endfunction

    function automatic exp_t observed();
        return {bus.player_x, bus.player_state, bus.attack_active};
    endfunction

    task automatic model_reset();
        m_x = START_X; m_state = S_IDLE; m_cnt = 0; m_prev = 0; m_hit = 0;
    endtask

    // One-cycle frame_tick with the given inputs; the model predicts the outputs.
    task automatic drive_tick(input bit l, input bit r, input bit a, input bit h,
                              input int opp, input bit gap);
        exp_t e;
        bit   pending, press;
        int   nx, lim;
        bus.btn_left = l; bus.btn_right = r; bus.btn_attack = a; bus.got_hit = h;
        bus.opponent_x = 10'(opp); bus.frame_tick = 1'b1;
        pending = m_hit || h;
        press   = a && !m_prev;
        if (pending && m_state != S_HIT) begin
            m_state = S_HIT; m_cnt = HITSTUN_FRAMES - 1;
        end else if (m_state <= S_BACK) begin
            if (press) begin
                m_state = S_START; m_cnt = STARTUP_FRAMES - 1;
            end else if (r && !l) begin
                nx = m_x + SPEED_FWD;
                if (nx > X_MAX - PLAYER_W) nx = X_MAX - PLAYER_W;
                lim = opp - PLAYER_W;
                if (lim < X_MIN) lim = X_MIN;
                if (nx > lim) nx = (m_x > lim) ? m_x : lim;
                m_x = nx; m_state = S_FWD;
            end else if (l && !r) begin
                nx = m_x - SPEED_BACK;
                if (nx < X_MIN) nx = X_MIN;
                m_x = nx; m_state = S_BACK;
            end else begin
                m_state = S_IDLE;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else begin
            case (m_state)
                S_START: begin m_state = S_ACT; m_cnt = ACTIVE_FRAMES - 1; end
                S_ACT:   begin m_state = S_REC; m_cnt = RECOVERY_FRAMES - 1; end
                default: m_state = S_IDLE;
            endcase
        end
        m_prev = a; m_hit = 0;
        e.x = 10'(m_x); e.st = 4'(m_state); e.atk = (m_state == S_ACT);
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.frame_tick = 1'b0; bus.got_hit = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // got_hit pulse in a cycle without frame_tick.
    task automatic pulse_hit();
        bus.got_hit = 1'b1; m_hit = 1;
        @(posedge clk); #1;
        bus.got_hit = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got, e;
        reset = 1'b1; bus.got_hit = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.got_hit = 1'b0;
        model_reset();
        e = {10'(START_X), 4'd0, 1'b0};
        got = observed();
        chk_cnt++;
        if (got !== e) $display("FAIL reset_values: got %s, expected %s", fmt(got), fmt(e));
        else begin pass_cnt++; $display("reset: %s", fmt(got)); end
        bus.btn_right = 1'b1; bus.btn_attack = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        got = observed();
        chk_cnt++;
        if (got !== e) $display("FAIL no_tick_hold: got %s, expected %s", fmt(got), fmt(e));
        else begin pass_cnt++; $display("no tick hold: %s", fmt(got)); end
        // hit raised during reset must have been discarded
        drive_tick(0, 0, 0, 0, 600, 1);
        e = exp_q.pop_front(); got = observed(); chk_cnt++;
        if (got !== e) $display("FAIL reset_first_tick: got %s, expected %s", fmt(got), fmt(e));
        else begin pass_cnt++; $display("first tick: %s", fmt(got)); end
    endtask

    task automatic test_walk();
        phase_t tbl[2];
        exp_t got, e;
        tbl[0] = '{0, 1, 0, 600, 10, 130, S_FWD};
        tbl[1] = '{1, 0, 0, 600, 5, 120, S_BACK};
        foreach (tbl[p]) begin
            for (int i = 0; i < tbl[p].n; i++) begin
                drive_tick(tbl[p].l, tbl[p].r, tbl[p].a, 0, tbl[p].opp, 1);
                e = exp_q.pop_front(); got = observed(); chk_cnt++;
                if (got !== e) $display("FAIL walk p%0d t%0d: got %s, expected %s", p, i, fmt(got), fmt(e));
                else begin pass_cnt++; $display("walk p%0d t%0d: %s", p, i, fmt(got)); end
            end
            chk_cnt++;
            if (bus.player_x !== 10'(tbl[p].exp_x) || bus.player_state !== 4'(tbl[p].exp_st))
                $display("FAIL walk_end p%0d: got x=%0d st=%0d, expected x=%0d st=%0d",
                         p, bus.player_x, bus.player_state, tbl[p].exp_x, tbl[p].exp_st);
            else pass_cnt++;
        end
    endtask

    task automatic test_edges();
        phase_t tbl[7];
        exp_t got, e;
        tbl[0] = '{0, 1, 0, 600, 1, 123, S_FWD};
        tbl[1] = '{1, 0, 0, 600, 61, 1, S_BACK};
        tbl[2] = '{1, 0, 0, 600, 1, 0, S_BACK};
        tbl[3] = '{0, 1, 0, 700, 200, 576, S_FWD};
        tbl[4] = '{1, 0, 0, 700, 230, 116, S_BACK};
        tbl[5] = '{0, 1, 0, 200, 10, 136, S_FWD};
        tbl[6] = '{1, 1, 0, 200, 1, 136, S_IDLE};
        foreach (tbl[p]) begin
            for (int i = 0; i < tbl[p].n; i++) begin
                drive_tick(tbl[p].l, tbl[p].r, tbl[p].a, 0, tbl[p].opp, 1);
                e = exp_q.pop_front(); got = observed(); chk_cnt++;
                if (got !== e) $display("FAIL edge p%0d t%0d: got %s, expected %s", p, i, fmt(got), fmt(e));
                else begin pass_cnt++; $display("edge p%0d t%0d: %s", p, i, fmt(got)); end
            end
            chk_cnt++;
            if (bus.player_x !== 10'(tbl[p].exp_x) || bus.player_state !== 4'(tbl[p].exp_st))
                $display("FAIL edge_end p%0d: got x=%0d st=%0d, expected x=%0d st=%0d",
                         p, bus.player_x, bus.player_state, tbl[p].exp_x, tbl[p].exp_st);
            else pass_cnt++;
        end
    endtask

    task automatic test_attack();
        exp_t got, e;
        int   seen[7];
        foreach (seen[k]) seen[k] = 0;
        drive_tick(0, 0, 0, 0, 600, 1);
        e = exp_q.pop_front(); got = observed(); chk_cnt++;
        if (got !== e) $display("FAIL attack_pre: got %s, expected %s", fmt(got), fmt(e));
        else begin pass_cnt++; $display("attack pre: %s", fmt(got)); end
        for (int i = 0; i < 30; i++) begin
            drive_tick(0, 0, 1, 0, 600, 1);
            e = exp_q.pop_front(); got = observed(); chk_cnt++;
            if (got !== e) $display("FAIL attack t%0d: got %s, expected %s", i, fmt(got), fmt(e));
            else begin pass_cnt++; $display("attack t%0d: %s", i, fmt(got)); end
            if (bus.player_state < 4'd7) seen[bus.player_state]++;
        end
        chk_cnt++;
        if (seen[S_START] != STARTUP_FRAMES || seen[S_ACT] != ACTIVE_FRAMES ||
            seen[S_REC] != RECOVERY_FRAMES || seen[S_IDLE] != 7)
            $display("FAIL attack_phase_len: got %0d/%0d/%0d idle %0d, expected 5/2/16 idle 7",
                     seen[S_START], seen[S_ACT], seen[S_REC], seen[S_IDLE]);
        else pass_cnt++;
    endtask

    task automatic test_hitstun();
        exp_t got, e;
        int   hs;
        drive_tick(0, 0, 0, 0, 600, 1);
        void'(exp_q.pop_front());
        drive_tick(0, 0, 1, 0, 600, 1);
        e = exp_q.pop_front(); got = observed(); chk_cnt++;
        if (got !== e) $display("FAIL hit_press: got %s, expected %s", fmt(got), fmt(e));
        else begin pass_cnt++; $display("hit press: %s", fmt(got)); end
        drive_tick(0, 0, 0, 0, 600, 1);
        void'(exp_q.pop_front());
        pulse_hit();
        hs = 0;
        for (int i = 0; i < 25; i++) begin
            drive_tick(0, 0, 0, 0, 600, 1);
            e = exp_q.pop_front(); got = observed(); chk_cnt++;
            if (got !== e) $display("FAIL hitstun t%0d: got %s, expected %s", i, fmt(got), fmt(e));
            else begin pass_cnt++; $display("hitstun t%0d: %s", i, fmt(got)); end
            if (bus.player_state == 4'(S_HIT)) hs++;
            if (m_state == S_HIT) pulse_hit();
        end
        chk_cnt++;
        if (hs != HITSTUN_FRAMES || bus.player_state !== 4'(S_IDLE))
            $display("FAIL hitstun_len: got %0d ticks end st=%0d, expected 20 ticks end st=0",
                     hs, bus.player_state);
        else pass_cnt++;
        // hit coincident with the tick itself
        drive_tick(0, 1, 0, 1, 600, 1);
        e = exp_q.pop_front(); got = observed(); chk_cnt++;
        if (got !== e || bus.player_state !== 4'(S_HIT))
            $display("FAIL hit_on_tick: got %s, expected %s", fmt(got), fmt(e));
        else begin pass_cnt++; $display("hit on tick: %s", fmt(got)); end
        for (int i = 0; i < HITSTUN_FRAMES; i++) begin
            drive_tick(0, 0, 0, 0, 600, 1);
            e = exp_q.pop_front(); got = observed(); chk_cnt++;
            if (got !== e) $display("FAIL hit_clear t%0d: got %s, expected %s", i, fmt(got), fmt(e));
            else begin pass_cnt++; $display("hit clear t%0d: %s", i, fmt(got)); end
        end
    endtask

    task automatic test_reset_mid_attack();
        exp_t got, e;
        for (int i = 0; i < 10; i++) begin
            drive_tick(0, (i < 4), (i == 4), 0, 600, 1);
            e = exp_q.pop_front(); got = observed(); chk_cnt++;
            if (got !== e) $display("FAIL pre_reset t%0d: got %s, expected %s", i, fmt(got), fmt(e));
            else begin pass_cnt++; $display("pre reset t%0d: %s", i, fmt(got)); end
        end
        chk_cnt++;
        if (bus.attack_active !== 1'b1)
            $display("FAIL in_active: got atk=%0d, required 1", bus.attack_active);
        else pass_cnt++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        e = {10'(START_X), 4'd0, 1'b0};
        got = observed(); chk_cnt++;
        if (got !== e) $display("FAIL reset_mid_attack: got %s, expected %s", fmt(got), fmt(e));
        else begin pass_cnt++; $display("reset mid attack: %s", fmt(got)); end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        for (int i = 0; i < 8; i++) begin
            drive_tick(0, 1, 0, 0, 700, 0);
            e = exp_q.pop_front(); got = observed(); chk_cnt++;
            if (got !== e) $display("FAIL b2b t%0d: got %s, expected %s", i, fmt(got), fmt(e));
            else begin pass_cnt++; $display("b2b t%0d: %s", i, fmt(got)); end
        end
        chk_cnt++;
        if (bus.player_x !== 10'(START_X + 8 * SPEED_FWD))
            $display("FAIL b2b_end: got x=%0d, expected x=%0d", bus.player_x, START_X + 8 * SPEED_FWD);
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.frame_tick = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
        bus.btn_attack = 1'b0; bus.got_hit = 1'b0; bus.opponent_x = 10'd600;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_walk();
        test_edges();
        test_attack();
        test_hitstun();
        test_reset_mid_attack();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
